// File: rtl/mttkrp_factor_fetch_if.sv
// ---------------------------------------------------------------------------
// mttkrp_factor_fetch_if
//
// Bundles every non-clock, non-reset signal of the factor-row fetch unit.
// Bundled signals:
//   Request side (compute units):
//     req_addr_en       NM          per-mode valid, request present when all set
//     req_addr          NM*AW       row address per mode
//     req_compute_id    IDW         requesting compute unit
//     req_ready         1           request queue not full
//   Factor memory side:
//     mem_rd_en         NM          per-mode read request (registered)
//     mem_rd_addr       NM*AW       read address, stable until accepted
//     mem_rd_ready      NM          memory accepts the read
//     mem_rd_valid      NM          returned row valid
//     mem_rd_data       NM*RW       returned rows
//   Delivery side (accelerator):
//     factor_en         NM          delivered rows valid (all bits together)
//     factor_data       NM*RW       delivered rows
//     factor_compute_id IDW         owner of the delivered rows
//     factor_data_ack   1           one-cycle pulse with factor_en
//   Misc:
//     cache_flush       1           invalidate the last-row cache
//     busy              1           fetch in progress or requests queued
//
// Modports: slave = the fetch unit, master = its environment.
// ---------------------------------------------------------------------------
interface mttkrp_factor_fetch_if #(
    parameter int TENSOR_DIMENSIONS      = 3,
    parameter int FACTOR_MATRIX_WIDTH    = 32,
    parameter int RANK_FACTOR_MATRIX     = 16,
    parameter int MODE_TENSOR_ADDR_WIDTH = 16,
    parameter int NUM_COMPUTE_UNITS      = 4
);
    localparam int NM  = TENSOR_DIMENSIONS - 1;
    localparam int AW  = MODE_TENSOR_ADDR_WIDTH;
    localparam int RW  = RANK_FACTOR_MATRIX * FACTOR_MATRIX_WIDTH;
    localparam int IDW = $clog2(NUM_COMPUTE_UNITS) + 1;

    logic [NM-1:0]    req_addr_en;
    logic [NM*AW-1:0] req_addr;
    logic [IDW-1:0]   req_compute_id;
    logic             req_ready;

    logic [NM-1:0]    mem_rd_en;
    logic [NM*AW-1:0] mem_rd_addr;
    logic [NM-1:0]    mem_rd_ready;
    logic [NM-1:0]    mem_rd_valid;
    logic [NM*RW-1:0] mem_rd_data;

    logic [NM-1:0]    factor_en;
    logic [NM*RW-1:0] factor_data;
    logic [IDW-1:0]   factor_compute_id;
    logic             factor_data_ack;

    logic             cache_flush;
    logic             busy;

    modport slave (
        input  req_addr_en, req_addr, req_compute_id,
        output req_ready,
        output mem_rd_en, mem_rd_addr,
        input  mem_rd_ready, mem_rd_valid, mem_rd_data,
        output factor_en, factor_data, factor_compute_id, factor_data_ack,
        input  cache_flush,
        output busy
    );

    modport master (
        output req_addr_en, req_addr, req_compute_id,
        input  req_ready,
        input  mem_rd_en, mem_rd_addr,
        output mem_rd_ready, mem_rd_valid, mem_rd_data,
        input  factor_en, factor_data, factor_compute_id, factor_data_ack,
        output cache_flush,
        input  busy
    );
endinterface

// File: rtl/mttkrp_factor_fetch.sv
// ---------------------------------------------------------------------------
// mttkrp_factor_fetch
//
// Queues factor-row requests (one row address per non-output mode plus a
// compute ID), reads one rank-wide row per mode from factor memory and
// delivers all rows together for one cycle, tagged with the compute ID.
// One request is in flight at a time; each mode has at most one read
// outstanding and modes may complete in any order.
//
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - mttkrp_factor_fetch_if.slave (request, memory, delivery, flush,
//          busy signals)
//
// Build option: define FACTOR_ROW_CACHE_EN to add a last-row cache per mode
// that serves repeated addresses without a memory read. Without it,
// cache_flush is ignored and every mode always reads memory.
// ---------------------------------------------------------------------------
module mttkrp_factor_fetch #(
    parameter int TENSOR_DIMENSIONS      = 3,
    parameter int FACTOR_MATRIX_WIDTH    = 32,
    parameter int RANK_FACTOR_MATRIX     = 16,
    parameter int MODE_TENSOR_ADDR_WIDTH = 16,
    parameter int NUM_COMPUTE_UNITS      = 4,
    parameter int REQ_FIFO_DEPTH         = 4
) (
    input logic                  clk,
    input logic                  rst,
    mttkrp_factor_fetch_if.slave bus
);
    localparam int NM  = TENSOR_DIMENSIONS - 1;
    localparam int AW  = MODE_TENSOR_ADDR_WIDTH;
    localparam int RW  = RANK_FACTOR_MATRIX * FACTOR_MATRIX_WIDTH;
    localparam int IDW = $clog2(NUM_COMPUTE_UNITS) + 1;
    localparam int PW  = $clog2(REQ_FIFO_DEPTH) + 1;
    localparam int FE  = NM * AW + IDW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DELIVER
    } state_e;

    // ---------------------------------------------------------------------
    // Request FIFO. The extra pointer bit tells full from empty.
    // ---------------------------------------------------------------------
    logic [FE-1:0]    fifo_mem [REQ_FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic             fifo_empty, fifo_full, push, pop;
    logic [FE-1:0]    head;
    logic [NM*AW-1:0] head_addr;
    logic [IDW-1:0]   head_id;

    state_e state_q, state_d;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                        (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);

    assign bus.req_ready = !rst && !fifo_full;
    assign push          = (&bus.req_addr_en) && bus.req_ready;
    assign pop           = (state_q == S_IDLE) && !fifo_empty;

    assign head      = fifo_mem[rd_ptr_q[PW-2:0]];
    assign head_addr = head[FE-1:IDW];
    assign head_id   = head[IDW-1:0];

    // NOTE: storage arrays are not reset; the pointers alone decide which
    // entries are live, so resetting the array would only cost area.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[PW-2:0]] <= {bus.req_addr, bus.req_compute_id};
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    // ---------------------------------------------------------------------
    // Working request and per-mode progress.
    // ---------------------------------------------------------------------
    logic [NM*AW-1:0] addr_q, addr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [NM-1:0]    issued_q, issued_d;
    logic [NM-1:0]    got_q, got_d;
    logic [NM-1:0]    rd_en_q, rd_en_d;
    logic [NM*RW-1:0] row_q, row_d;
    logic [NM*RW-1:0] factor_data_q, factor_data_d;
    logic [NM-1:0]    capture;
    logic [NM-1:0]    hit;
    logic [NM*RW-1:0] hit_row;

    // A returned row counts only for an issued, not yet completed mode;
    // anything else (stray or late valid) is dropped.
    always_comb begin
        for (int m = 0; m < NM; m++) begin
            capture[m] = (state_q == S_FETCH) && bus.mem_rd_valid[m] &&
                         issued_q[m] && !got_q[m];
        end
    end

`ifdef FACTOR_ROW_CACHE_EN
    logic [NM-1:0]    cache_vld_q;
    logic [NM*AW-1:0] cache_addr_q;
    logic [NM*RW-1:0] cache_row_q;

    // A flush in the pop cycle suppresses the hit: flush wins.
    always_comb begin
        for (int m = 0; m < NM; m++) begin
            hit[m] = cache_vld_q[m] && !bus.cache_flush &&
                     (cache_addr_q[m*AW +: AW] == head_addr[m*AW +: AW]);
        end
    end
    assign hit_row = cache_row_q;

    always_ff @(posedge clk) begin
        if (rst || bus.cache_flush) begin
            cache_vld_q <= '0;
        end else begin
            cache_vld_q <= cache_vld_q | capture;
        end
    end

    always_ff @(posedge clk) begin
        for (int m = 0; m < NM; m++) begin
            if (capture[m]) begin
                cache_addr_q[m*AW +: AW] <= addr_q[m*AW +: AW];
                cache_row_q[m*RW +: RW]  <= bus.mem_rd_data[m*RW +: RW];
            end
        end
    end
`else
    logic unused_cache_flush;
    assign unused_cache_flush = bus.cache_flush;
    assign hit                = '0;
    assign hit_row            = '0;
`endif

    // ---------------------------------------------------------------------
    // FSM next state and datapath.
    // ---------------------------------------------------------------------
    // NOTE: every variable gets its hold value first, so no path through
    // this block leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        id_d          = id_q;
        issued_d      = issued_q;
        got_d         = got_q;
        rd_en_d       = rd_en_q;
        row_d         = row_q;
        factor_data_d = factor_data_q;

        unique case (state_q)
            S_IDLE: begin
                if (pop) begin
                    addr_d   = head_addr;
                    id_d     = head_id;
                    // Cache hits complete immediately and never touch memory.
                    issued_d = hit;
                    got_d    = hit;
                    rd_en_d  = ~hit;
                    for (int m = 0; m < NM; m++) begin
                        if (hit[m]) row_d[m*RW +: RW] = hit_row[m*RW +: RW];
                    end
                    state_d  = S_FETCH;
                end
            end
            S_FETCH: begin
                for (int m = 0; m < NM; m++) begin
                    if (rd_en_q[m] && bus.mem_rd_ready[m]) begin
                        issued_d[m] = 1'b1;
                        rd_en_d[m]  = 1'b0;
                    end
                    if (capture[m]) begin
                        got_d[m]          = 1'b1;
                        row_d[m*RW +: RW] = bus.mem_rd_data[m*RW +: RW];
                    end
                end
                // Looking at got_d lets the last row go straight to DELIVER.
                if (&got_d) begin
                    factor_data_d = row_d;
                    state_d       = S_DELIVER;
                end
            end
            S_DELIVER: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            id_q          <= '0;
            issued_q      <= '0;
            got_q         <= '0;
            rd_en_q       <= '0;
            row_q         <= '0;
            factor_data_q <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            id_q          <= id_d;
            issued_q      <= issued_d;
            got_q         <= got_d;
            rd_en_q       <= rd_en_d;
            row_q         <= row_d;
            factor_data_q <= factor_data_d;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs.
    // ---------------------------------------------------------------------
    assign bus.mem_rd_en         = rd_en_q;
    assign bus.mem_rd_addr       = addr_q;
    assign bus.factor_en         = {NM{state_q == S_DELIVER}};
    assign bus.factor_data_ack   = (state_q == S_DELIVER);
    assign bus.factor_data       = factor_data_q;
    assign bus.factor_compute_id = (state_q == S_DELIVER) ? id_q
                                                          : IDW'(NUM_COMPUTE_UNITS);
    assign bus.busy              = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_mttkrp_factor_fetch.sv
module tb_mttkrp_factor_fetch;
    localparam int TD    = 3;
    localparam int FW    = 32;
    localparam int RANK  = 16;
    localparam int AW    = 16;
    localparam int NCU   = 4;
    localparam int DEPTH = 4;
    localparam int NM    = TD - 1;
    localparam int RW    = RANK * FW;
    localparam int IDW   = $clog2(NCU) + 1;

`ifdef FACTOR_ROW_CACHE_EN
    localparam bit CACHE_ON = 1'b1;
`else
    localparam bit CACHE_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    mttkrp_factor_fetch_if #(
        .TENSOR_DIMENSIONS(TD), .FACTOR_MATRIX_WIDTH(FW), .RANK_FACTOR_MATRIX(RANK),
        .MODE_TENSOR_ADDR_WIDTH(AW), .NUM_COMPUTE_UNITS(NCU)
    ) bus ();

    mttkrp_factor_fetch #(
        .TENSOR_DIMENSIONS(TD), .FACTOR_MATRIX_WIDTH(FW), .RANK_FACTOR_MATRIX(RANK),
        .MODE_TENSOR_ADDR_WIDTH(AW), .NUM_COMPUTE_UNITS(NCU), .REQ_FIFO_DEPTH(DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory contents: element i of mode m at address a.
    function automatic logic [RW-1:0] row_of(input int m, input logic [AW-1:0] a);
        logic [RW-1:0] r;
        logic [3:0]    tag;
        tag = 4'hA + 4'(m);
        for (int i = 0; i < RANK; i++) r[i*FW +: FW] = {tag, 12'(i), a};
        return r;
    endfunction

    function automatic logic [NM*RW-1:0] exp_rows(input logic [NM*AW-1:0] a);
        logic [NM*RW-1:0] r;
        for (int m = 0; m < NM; m++) r[m*RW +: RW] = row_of(m, a[m*AW +: AW]);
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Memory model: accepts when en && ready, returns lat[m] cycles later.
    // ------------------------------------------------------------------
    logic [NM-1:0]    ready_ctl   = '1;
    logic [NM-1:0]    stray_valid = '0;
    logic [NM-1:0]    mdl_valid   = '0;
    logic [NM*RW-1:0] mem_data    = '0;
    logic [NM-1:0]    pend        = '0;
    int               cnt [NM];
    logic [AW-1:0]    pend_addr [NM];
    int               rd_count [NM];
    int               lat [NM];

    assign bus.mem_rd_ready = ready_ctl;
    assign bus.mem_rd_valid = mdl_valid | stray_valid;
    assign bus.mem_rd_data  = mem_data;

    always @(negedge clk) begin
        for (int m = 0; m < NM; m++) begin
            mdl_valid[m] = 1'b0;
            if (pend[m]) begin
                if (cnt[m] <= 1) begin
                    mdl_valid[m]           = 1'b1;
                    mem_data[m*RW +: RW]   = row_of(m, pend_addr[m]);
                    pend[m]                = 1'b0;
                end else begin
                    cnt[m]--;
                end
            end
            if (!rst && bus.mem_rd_en[m] && bus.mem_rd_ready[m]) begin
                pend[m]      = 1'b1;
                cnt[m]       = lat[m];
                pend_addr[m] = bus.mem_rd_addr[m*AW +: AW];
                rd_count[m]++;
            end
        end
    end

    function automatic int reads_total();
        int s = 0;
        for (int m = 0; m < NM; m++) s += rd_count[m];
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Scoreboard and delivery monitor.
    // ------------------------------------------------------------------
    typedef struct {
        logic [IDW-1:0]   id;
        logic [NM*RW-1:0] data;
    } exp_t;

    exp_t sb [$];
    int   deliv_n   = 0;
    int   deliv_cyc = 0;
    logic prev_en   = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_en = 1'b0;
        end else if (bus.factor_en != '0) begin
            deliv_n++;
            deliv_cyc = cyc;
            check("deliv_en_all", bus.factor_en, {NM{1'b1}});
            check("deliv_ack", bus.factor_data_ack, 1);
            check("deliv_single_cycle", prev_en, 0);
            check("deliv_pending", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("deliv_id", bus.factor_compute_id, e.id);
                for (int m = 0; m < NM; m++)
                    check("deliv_row", bus.factor_data[m*RW +: RW], e.data[m*RW +: RW]);
            end
            prev_en = 1'b1;
        end else begin
            check("idle_ack", bus.factor_data_ack, 0);
            check("idle_id", bus.factor_compute_id, NCU);
            prev_en = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers; inputs change 1 time unit after the rising edge.
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a request and holds it until taken; leaves it driven.
    task automatic push_req(input logic [NM*AW-1:0] addrs, input logic [IDW-1:0] id,
                            output int pcyc, output int waited);
        exp_t e;
        bus.req_addr_en    = '1;
        bus.req_addr       = addrs;
        bus.req_compute_id = id;
        waited = 0;
        @(negedge clk);
        while (!bus.req_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("push_accept", bus.req_ready, 1);
        pcyc   = cyc;
        e.id   = id;
        e.data = exp_rows(addrs);
        sb.push_back(e);
        step();
    endtask

    task automatic req_idle();
        bus.req_addr_en = '0;
    endtask

    task automatic wait_deliv(input int target, input int budget);
        int w = 0;
        while (deliv_n < target && w < budget) begin
            @(negedge clk);
            w++;
        end
        check("deliv_count", deliv_n, target);
    endtask

    typedef struct {
        logic [NM*AW-1:0] addrs;
        logic [IDW-1:0]   id;
        int               lat0;
        int               lat1;
        int               exp_lat;
    } vec_t;

    vec_t vec [5];

    initial begin
        int               pc, w, base, r0;
        logic [NM*RW-1:0] fd;
        logic [NM*AW-1:0] a;

        // {mode1 addr, mode0 addr}, id, mode latencies, push-to-deliver cycles
        vec[0] = '{{16'h0020, 16'h0010}, 3'd2, 1, 1, 4};
        vec[1] = '{{16'h0200, 16'h0100}, 3'd1, 6, 1, 9};
        vec[2] = '{{16'hBEEF, 16'h1234}, 3'd3, 2, 3, 6};
        vec[3] = '{{16'h0000, 16'hFFFF}, 3'd0, 1, 4, 7};
        vec[4] = '{{16'h8000, 16'h0001}, 3'd1, 3, 3, 6};

        for (int m = 0; m < NM; m++) begin
            rd_count[m] = 0;
            lat[m]      = 1;
            cnt[m]      = 0;
            pend_addr[m] = '0;
        end
        bus.req_addr_en    = '0;
        bus.req_addr       = '0;
        bus.req_compute_id = '0;
        bus.cache_flush    = 1'b0;

        // ---------------- reset values ----------------
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_mem_rd_en", bus.mem_rd_en, 0);
        check("rst_mem_rd_addr", bus.mem_rd_addr, 0);
        check("rst_factor_en", bus.factor_en, 0);
        check("rst_factor_id", bus.factor_compute_id, NCU);
        check("rst_ack", bus.factor_data_ack, 0);
        check("rst_busy", bus.busy, 0);
        for (int m = 0; m < NM; m++) check("rst_factor_data", bus.factor_data[m*RW +: RW], 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", bus.req_ready, 1);
        step();

        // ---------------- stray valid in IDLE ----------------
        fd = bus.factor_data;
        stray_valid = 2'b01;
        step();
        stray_valid = '0;
        repeat (3) begin
            @(negedge clk);
            check("stray_busy", bus.busy, 0);
            check("stray_rd_en", bus.mem_rd_en, 0);
            for (int m = 0; m < NM; m++) check("stray_data", bus.factor_data[m*RW +: RW], fd[m*RW +: RW]);
        end
        check("stray_no_deliv", deliv_n, 0);
        step();

        // ---------------- table-driven single requests ----------------
        for (int v = 0; v < 5; v++) begin
            lat[0] = vec[v].lat0;
            lat[1] = vec[v].lat1;
            base   = deliv_n;
            r0     = reads_total();
            push_req(vec[v].addrs, vec[v].id, pc, w);
            req_idle();
            wait_deliv(base + 1, 40);
            check("vec_latency", deliv_cyc - pc, vec[v].exp_lat);
            check("vec_reads", reads_total() - r0, NM);
            step();
            @(negedge clk);
            check("vec_busy_after", bus.busy, 0);
            step();
        end

        // ---------------- backpressure ----------------
        lat[0] = 1;
        lat[1] = 1;
        ready_ctl = '0;
        base = deliv_n;
        for (int k = 0; k < 5; k++) begin
            a = {16'h0400 + 16'(k), 16'h0300 + 16'(k)};
            push_req(a, IDW'(k % NCU), pc, w);
            check("bp_push_no_wait", w, 0);
        end
        bus.req_addr       = {16'h0405, 16'h0305};
        bus.req_compute_id = IDW'(5 % NCU);
        repeat (3) begin
            @(negedge clk);
            check("bp_req_ready_low", bus.req_ready, 0);
            check("bp_busy", bus.busy, 1);
            check("bp_rd_en_held", bus.mem_rd_en, {NM{1'b1}});
            check("bp_rd_addr_held", bus.mem_rd_addr, {16'h0400, 16'h0300});
        end
        step();
        ready_ctl = '1;
        push_req({16'h0405, 16'h0305}, IDW'(5 % NCU), pc, w);
        req_idle();
        wait_deliv(base + 6, 200);
        check("bp_sb_drained", sb.size(), 0);
        step();

        // ---------------- repeated addresses and flush ----------------
        a = {16'h0555, 16'h0777};
        base = deliv_n;
        r0 = reads_total();
        push_req(a, 3'd1, pc, w);
        req_idle();
        wait_deliv(base + 1, 40);
        check("rep1_latency", deliv_cyc - pc, 4);
        check("rep1_reads", reads_total() - r0, NM);
        step();

        r0 = reads_total();
        push_req(a, 3'd2, pc, w);
        req_idle();
        wait_deliv(base + 2, 40);
        check("rep2_latency", deliv_cyc - pc, CACHE_ON ? 3 : 4);
        check("rep2_reads", reads_total() - r0, CACHE_ON ? 0 : NM);
        step();

        // Flush lands in the same cycle the request is popped.
        r0 = reads_total();
        push_req(a, 3'd3, pc, w);
        req_idle();
        bus.cache_flush = 1'b1;
        step();
        bus.cache_flush = 1'b0;
        wait_deliv(base + 3, 40);
        check("flush_latency", deliv_cyc - pc, 4);
        check("flush_reads", reads_total() - r0, NM);
        step();

        r0 = reads_total();
        push_req(a, 3'd0, pc, w);
        req_idle();
        wait_deliv(base + 4, 40);
        check("refill_latency", deliv_cyc - pc, CACHE_ON ? 3 : 4);
        check("refill_reads", reads_total() - r0, CACHE_ON ? 0 : NM);
        step();

        // ---------------- reset during FETCH ----------------
        lat[0] = 4;
        lat[1] = 4;
        base = deliv_n;
        push_req({16'h0AAA, 16'h0BBB}, 3'd2, pc, w);
        req_idle();
        step();
        @(negedge clk);
        check("midrst_rd_en", bus.mem_rd_en, {NM{1'b1}});
        check("midrst_busy_before", bus.busy, 1);
        step();
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        check("midrst_ready_low", bus.req_ready, 0);
        step();
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("midrst_no_deliv", deliv_n, base);
        check("midrst_busy", bus.busy, 0);
        check("midrst_req_ready", bus.req_ready, 1);
        check("midrst_rd_en_clear", bus.mem_rd_en, 0);
        check("midrst_model_idle", pend, 0);
        step();

        // Recovery after the abort.
        lat[0] = 1;
        lat[1] = 1;
        push_req({16'h0DEF, 16'h0ABC}, 3'd2, pc, w);
        req_idle();
        wait_deliv(base + 1, 40);
        check("recover_latency", deliv_cyc - pc, 4);
        step();
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end
endmodule
